// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: issues fetch addresses over valid/ready and applies J/branch/JR redirects.
// Optional build macro BRANCH_DELAY_SLOT_EN selects MIPS delay-slot semantics (no flush, redirect after ctrl_pc+4).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_ready,
  output logic        fetch_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_pc,
  input  logic        jump_en,
  input  logic [25:0] jump_addr,
  input  logic        branch_en,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic        flush,
  output logic        redirect_busy,
  output logic        addr_err
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] r_pend;
  logic [AW-1:0] w_pend_nxt;
  logic          r_outstanding;
  logic          w_outstanding_nxt;

  logic [AW-1:0] w_seq_pc;
  logic [AW-1:0] w_slot_pc;
  logic [AW-1:0] w_jump_tgt;
  logic [AW-1:0] w_br_off;
  logic [AW-1:0] w_br_tgt;
  logic [AW-1:0] w_jr_tgt;
  logic [AW-1:0] w_target;
  logic          w_req;
  logic          w_fv;
  logic          w_accept;
  logic          w_defer;
  logic          w_flush;
  logic          w_addr_err;

  // Target computation relative to the slot address ctrl_pc+4
  assign w_seq_pc   = r_pc + AW'(4);
  assign w_slot_pc  = ctrl_pc + AW'(4);
  assign w_jump_tgt = {w_slot_pc[31:28], jump_addr, 2'b00};
  assign w_br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign w_br_tgt   = w_slot_pc + w_br_off;
  assign w_jr_tgt   = {jr_addr[31:2], 2'b00};

  // Redirect priority: jr > jump > branch
  always_comb begin
    w_target = w_br_tgt;
    if (jr_en) begin
      w_target = w_jr_tgt;
    end else if (jump_en) begin
      w_target = w_jump_tgt;
    end
  end

  assign w_req = ctrl_valid & (jr_en | jump_en | (branch_en & branch_taken));

  // A presented request holds until accepted; stall only gates a fresh issue
  assign w_fv     = rst_n & (r_state != S_BOOT) & (r_outstanding | ~stall);
  assign w_accept = w_fv & if_ready;

  // Next-state, PC update and combinational flush/addr_err
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_nxt        = r_pend;
    w_outstanding_nxt = w_fv & ~if_ready;
    w_flush           = 1'b0;
    w_addr_err        = 1'b0;
    w_defer           = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_req) begin
          w_addr_err = jr_en & ALIGN_CHECK & (jr_addr[1:0] != 2'b00);
`ifdef BRANCH_DELAY_SLOT_EN
          // The delay-slot word must be fetched before the redirect lands
          if (r_pc == w_slot_pc) begin
            w_defer = ~w_accept;
          end else begin
            w_defer = w_fv & ~if_ready;
          end
`else
          w_flush = 1'b1;
          w_defer = w_fv & ~if_ready;
`endif
          if (w_defer) begin
            w_pend_nxt  = w_target;
            w_state_nxt = S_HOLD;
          end else begin
            w_pc_nxt = w_target;
          end
        end else if (w_accept) begin
          w_pc_nxt = w_seq_pc;
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          w_pc_nxt    = r_pend;
          w_state_nxt = S_RUN;
`ifndef BRANCH_DELAY_SLOT_EN
          w_flush     = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_pend        <= '0;
      r_outstanding <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend        <= w_pend_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  assign fetch_valid   = w_fv;
  assign pc_out        = r_pc;
  assign pc_plus4      = w_seq_pc;
  assign flush         = rst_n & w_flush;
  assign addr_err      = rst_n & w_addr_err;
  assign redirect_busy = (r_state == S_HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue of expected fetch addresses is checked on every accepted fetch.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        if_ready = 1'b1;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        ctrl_valid = 1'b0;
  logic [31:0] ctrl_pc = '0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_addr = '0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        flush;
  logic        redirect_busy;
  logic        addr_err;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic [31:0] EXP_FL = 32'd0;
`else
  localparam logic [31:0] EXP_FL = 32'd1;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_ready(if_ready),
    .fetch_valid(fetch_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .ctrl_valid(ctrl_valid), .ctrl_pc(ctrl_pc), .jump_en(jump_en),
    .jump_addr(jump_addr), .branch_en(branch_en), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jr_en(jr_en), .jr_addr(jr_addr),
    .flush(flush), .redirect_busy(redirect_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to the sampling edge and score any accepted fetch
  task automatic to_neg();
    logic [31:0] e;
    @(negedge clk);
    if (fetch_valid === 1'b1 && if_ready === 1'b1) begin
      chk("sb_underflow", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("accept_addr", pc_out, e);
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ctrl_valid = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    branch_taken = 1'b0; jr_en = 1'b0;
  endtask

  initial begin
    // Reset, with a spurious request that must not flush
    to_pos();
    ctrl_valid = 1'b1; jump_en = 1'b1;
    to_neg();
    chk("rst_pc", pc_out, 32'h3000);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_busy", 32'(redirect_busy), 32'd0);
    chk("rst_aerr", 32'(addr_err), 32'd0);
    to_pos();
    clr(); rst_n = 1'b1;
    to_neg();
    chk("boot_fv", 32'(fetch_valid), 32'd0);
    chk("boot_pc", pc_out, 32'h3000);
    to_pos();
    sb_q.push_back(32'h3000); sb_q.push_back(32'h3004); sb_q.push_back(32'h3008);
    to_neg(); chk("run_fv", 32'(fetch_valid), 32'd1); to_pos();
    to_neg(); to_pos();
    to_neg(); to_pos();

    // Jump, pseudo-direct target
    sb_q.push_back(32'h300C);
    ctrl_valid = 1'b1; jump_en = 1'b1; ctrl_pc = 32'h1000_3010; jump_addr = 26'h000_0100;
    to_neg(); chk("jump_flush", 32'(flush), EXP_FL); chk("jump_busy", 32'(redirect_busy), 32'd0);
    to_pos(); clr();
    sb_q.push_back(32'h1000_0400);
    to_neg(); chk("post_jump_flush", 32'(flush), 32'd0); to_pos();

    // Backward taken branch, then not-taken
    sb_q.push_back(32'h1000_0404);
    ctrl_valid = 1'b1; branch_en = 1'b1; branch_taken = 1'b1;
    ctrl_pc = 32'h3020; branch_imm = 16'hFFFC;
    to_neg(); chk("br_flush", 32'(flush), EXP_FL); to_pos(); clr();
    sb_q.push_back(32'h3014);
    ctrl_valid = 1'b1; branch_en = 1'b1; branch_taken = 1'b0;
    to_neg(); chk("nt_flush", 32'(flush), 32'd0); chk("nt_plus4", pc_plus4, 32'h3018);
    to_pos(); clr();
    sb_q.push_back(32'h3018);
    to_neg(); to_pos();

    // Blocked fetch with misaligned JR
    if_ready = 1'b0;
    ctrl_valid = 1'b1; jr_en = 1'b1; jr_addr = 32'h0000_5002; ctrl_pc = 32'h3030;
    to_neg();
    chk("jr_aerr", 32'(addr_err), 32'd1);
    chk("jr_flush", 32'(flush), EXP_FL);
    chk("jr_fv", 32'(fetch_valid), 32'd1);
    chk("jr_pc", pc_out, 32'h301C);
    chk("jr_busy0", 32'(redirect_busy), 32'd0);
    to_pos(); clr();
    stall = 1'b1;
    to_neg();
    chk("hold_busy", 32'(redirect_busy), 32'd1);
    chk("hold_fv", 32'(fetch_valid), 32'd1);
    chk("hold_pc", pc_out, 32'h301C);
    chk("hold_flush", 32'(flush), 32'd0);
    chk("hold_aerr", 32'(addr_err), 32'd0);
    to_pos();
    // Release; a request arriving in HOLD is ignored
    stall = 1'b0; if_ready = 1'b1;
    ctrl_valid = 1'b1; jump_en = 1'b1; ctrl_pc = 32'h0; jump_addr = 26'h40;
    sb_q.push_back(32'h301C);
    to_neg(); chk("release_flush", 32'(flush), EXP_FL); chk("release_aerr", 32'(addr_err), 32'd0);
    to_pos(); clr();
    sb_q.push_back(32'h5000);
    to_neg(); chk("run_busy", 32'(redirect_busy), 32'd0); chk("run_flush", 32'(flush), 32'd0);
    to_pos();

    // Stall with and without an outstanding request
    stall = 1'b1;
    to_neg(); chk("stall_fv", 32'(fetch_valid), 32'd0); chk("stall_pc", pc_out, 32'h5004); to_pos();
    to_neg(); chk("stall_fv2", 32'(fetch_valid), 32'd0); chk("stall_pc2", pc_out, 32'h5004); to_pos();
    stall = 1'b0; if_ready = 1'b0;
    to_neg(); chk("issue_fv", 32'(fetch_valid), 32'd1); to_pos();
    stall = 1'b1;
    to_neg(); chk("out_stall_fv", 32'(fetch_valid), 32'd1); chk("out_stall_pc", pc_out, 32'h5004); to_pos();
    if_ready = 1'b1;
    sb_q.push_back(32'h5004);
    to_neg(); to_pos();
    stall = 1'b0;
    sb_q.push_back(32'h5008);
    to_neg(); to_pos();

    // Redirect while stalled and idle
    stall = 1'b1;
    ctrl_valid = 1'b1; jump_en = 1'b1; ctrl_pc = 32'h3010; jump_addr = 26'h000_0C40;
    to_neg(); chk("idle_redir_fv", 32'(fetch_valid), 32'd0); chk("idle_redir_flush", 32'(flush), EXP_FL);
    to_pos(); clr();

    // Aligned JR to top of memory, pc_plus4 wrap
    stall = 1'b0;
    ctrl_valid = 1'b1; jr_en = 1'b1; jr_addr = 32'hFFFF_FFFC;
    sb_q.push_back(32'h3100);
    to_neg(); chk("jr_ok_aerr", 32'(addr_err), 32'd0); to_pos(); clr();
    sb_q.push_back(32'hFFFF_FFFC);
    to_neg(); chk("wrap_plus4", pc_plus4, 32'h0); to_pos();
    sb_q.push_back(32'h0);
    to_neg(); chk("after_wrap_plus4", pc_plus4, 32'h4); to_pos();

    // Reset in HOLD discards the buffered target
    if_ready = 1'b0;
    ctrl_valid = 1'b1; jump_en = 1'b1; ctrl_pc = 32'h0; jump_addr = 26'h40;
    to_neg(); to_pos(); clr();
    to_neg(); chk("hold2_busy", 32'(redirect_busy), 32'd1); to_pos();
    rst_n = 1'b0;
    to_neg(); chk("rst_hold_fv", 32'(fetch_valid), 32'd0); chk("rst_hold_flush", 32'(flush), 32'd0);
    to_pos();
    rst_n = 1'b1;
    to_neg();
    chk("rst2_busy", 32'(redirect_busy), 32'd0);
    chk("rst2_pc", pc_out, 32'h3000);
    chk("rst2_fv", 32'(fetch_valid), 32'd0);
    to_pos();
    if_ready = 1'b1;
    sb_q.push_back(32'h3000);
    to_neg(); to_pos();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter for the MIPS core and sequences it.
- Each cycle it issues a fetch address to instruction memory over a valid/ready handshake.
- Redirects come from decode (J/JAL, taken branch, JR). Target computation is internal: J-type pseudo-direct concatenation, sign-extended branch offset, register target.
- Redirects that arrive while a fetch is outstanding are buffered. A flush is signalled for the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1, a JR target with [1:0]!=0 raises addr_err.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset
- stall  in  1  hazard stall from decode; suppresses issuing a new fetch
- if_ready  in  1  imem accepts the current fetch
- fetch_valid  out  1  pc_out is a valid fetch request
- pc_out  out  32  fetch address
- pc_plus4  out  32  pc_out+4, combinational, for link writeback
- ctrl_valid  in  1  decode presents a resolved control instruction this cycle
- ctrl_pc  in  32  PC of that control instruction
- jump_en  in  1  J/JAL
- jump_addr  in  26  instr_index field
- branch_en  in  1  conditional branch
- branch_taken  in  1  branch condition true
- branch_imm  in  16  offset field
- jr_en  in  1  JR/JALR
- jr_addr  in  32  rs value
- flush  out  1  discard the instruction currently in IF/ID
- redirect_busy  out  1  a redirect is buffered (state HOLD)
- addr_err  out  1  one-cycle pulse, misaligned JR target

Behaviour:
- Reset: clk single clock; reset is synchronous, active-low (rst_n sampled on rising clk). While rst_n=0:
  - pc_out=RESET_PC, state=BOOT.
  - fetch_valid=0, flush=0, redirect_busy=0, addr_err=0.
  - Pending target cleared.
  - Reset mid-HOLD discards the buffered target.
- Targets, computed from ctrl_pc, with S=ctrl_pc+4:
  - jump: {S[31:28], jump_addr, 2'b00}.
  - branch: S + {{14{imm[15]}}, imm, 2'b00}, 32-bit wrap-around, no overflow detect.
  - jr: {jr_addr[31:2], 2'b00}.
- Redirect request: req = ctrl_valid & (jr_en | jump_en | (branch_en & branch_taken)).
  - Priority jr > jump > branch if several are asserted.
  - branch_en with branch_taken=0 is not a redirect.
- Handshake:
  - A fetch is accepted on a cycle with fetch_valid & if_ready.
  - Once fetch_valid=1, pc_out and fetch_valid hold until accepted. stall is ignored for an outstanding request.
  - fetch_valid rises only when stall=0.
- States:
  - BOOT: fetch_valid=0 for one cycle, then RUN.
  - RUN, no req:
    - On accept, pc <= pc+4.
    - If not accepted, hold.
    - If stall=1 and no request is outstanding, fetch_valid=0 and pc holds.
  - RUN, req:
    - flush=1 this cycle (combinational from req).
    - If no fetch is outstanding, or it is accepted this cycle: pc <= target, stay in RUN.
    - Otherwise: latch target, go to HOLD, redirect_busy=1 from the next cycle.
  - HOLD:
    - Outstanding fetch is wrong-path.
    - On its acceptance: pc <= pending, go to RUN, flush=1 that cycle (the accepted wrong-path word is killed).
    - A new req in HOLD is ignored; decode is flushed, so it cannot legitimately occur.
- Latency: redirect visible on pc_out the cycle after req when no fetch is blocked.
- addr_err: asserted in the req cycle when jr wins, ALIGN_CHECK=1 and jr_addr[1:0]!=0. The redirect still proceeds with the aligned target.
- pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Optional Feature:
- BRANCH_DELAY_SLOT_EN. When defined, MIPS delay-slot semantics apply:
  - req does not assert flush.
  - Redirect is deferred until the fetch of ctrl_pc+4 has been accepted. If pc_out==ctrl_pc+4 and it is not yet accepted, the target is buffered (HOLD) and applied on that acceptance.
  - Once ctrl_pc+4 has been accepted, the target is applied on the next pc update.
  - flush is never asserted.
- When undefined: behaviour exactly as above, with no delay slot.

Test Plan:
- Reset: rst_n=0 for 2 clocks, then 1, if_ready=1 -> pc_out=32'h3000 throughout, fetch_valid=0 in BOOT. Accepted addresses are 3000, 3004, 3008.
- Jump: ctrl_pc=32'h1000_3010, jump_en=1, jump_addr=26'h000_0100, if_ready=1 -> flush=1 in the same cycle, next pc_out=32'h1000_0400.
- Backward branch: ctrl_pc=32'h3020, imm=16'hFFFC, taken=1 -> target 32'h3014. With taken=0 -> no flush, sequential +4.
- Blocked fetch: if_ready=0 while jr_en=1, jr_addr=32'h0000_5002 -> addr_err pulse, redirect_busy=1, pc_out held. When if_ready rises, flush=1 and the next pc_out=32'h5000.
- Stall: stall=1 with no request outstanding -> fetch_valid=0, pc_out constant. stall=1 asserted while fetch_valid=1 & if_ready=0 -> fetch_valid stays 1, pc_out stays unchanged until accepted.
- Delay slot (with BRANCH_DELAY_SLOT_EN): jump at ctrl_pc=3010, fetch of 3014 pending -> flush=0, 3014 accepted, then pc_out=target.
